// File: rtl/regfile_arb_pkg.sv
// Shared defaults and types for the register-file read-port arbiter.
//   NREQ_DEF / ADDR_W_DEF / DATA_W_DEF : default configuration
//   ptr_w()  : round-robin pointer width for a given requester count
//   rr_ptr_t : pointer / requester-id type for the default configuration
//   s1_t     : captured-request stage {valid, id, addr} for the default configuration
package regfile_arb_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 64;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [ptr_w(NREQ_DEF)-1:0] rr_ptr_t;

  typedef struct packed {
    logic                  valid;
    rr_ptr_t               id;
    logic [ADDR_W_DEF-1:0] addr;
  } s1_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : requester with highest priority this cycle
//   gnt : one-hot grant (all zero when no request)
//   idx : index of the granted requester (0 when none)
//   any : some requester was granted
module rr_grant
  import regfile_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = ptr_w(NREQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int d;
  int best;

  // Distance of requester i from ptr in round-robin order; the smallest
  // distance among active requesters wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    d    = 0;
    best = N;
    for (int i = 0; i < N; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + N;
      if (req[i] && (d < best)) begin
        best = d;
        idx  = IW'(i);
        any  = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++)
      gnt[i] = any && (idx == IW'(i));
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one combinational register-file read port among NREQ requesters.
// Round-robin grant with valid/ready handshake; the granted address is
// registered onto rf_rd_addr the next cycle, and the read data is registered
// with a one-hot response tag, giving a fixed two-cycle latency.
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per-requester read pending
//   req_addr    : per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   req_lock    : per-requester hold-grant request
//   req_ready   : one-hot grant
//   rf_rd_addr  : registered regfile read select
//   rf_rd_data  : combinational regfile read data
//   rsp_valid   : one-hot response tag
//   rsp_data    : response data
// Build option: define REGARB_LOCK_EN to let a locked grantee keep priority.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      rf_rd_addr,
  input  logic [DATA_W-1:0]      rf_rd_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data
);

  localparam int IW = ptr_w(NREQ);

  typedef struct packed {
    logic              valid;
    logic [IW-1:0]     id;
    logic [ADDR_W-1:0] addr;
  } stage_t;

  logic [IW-1:0]     ptr, ptr_nxt;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gidx;
  logic              gany;
  logic              xfer;
  logic [ADDR_W-1:0] addr_sel;
  logic [NREQ-1:0]   rsp_onehot;
  stage_t            s1;

  rr_grant #(.N(NREQ), .IW(IW)) u_grant (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // No grant may be seen by requesters while reset is held.
  assign req_ready = reset ? '0 : gnt;
  assign xfer      = gany & ~reset;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) addr_sel = addr_sel | req_addr[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    ptr_nxt = ptr;
    if (xfer) begin
      ptr_nxt = (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
`ifdef REGARB_LOCK_EN
      // A locked grantee stays at the head of the rotation.
      if (|(gnt & req_lock)) ptr_nxt = gidx;
`endif
    end
  end

`ifndef REGARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    rsp_onehot = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_onehot[i] = s1.valid && (s1.id == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      s1        <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      ptr      <= ptr_nxt;
      s1.valid <= xfer;
      // id/addr only move on a transfer so rf_rd_addr holds when idle.
      if (xfer) begin
        s1.id   <= gidx;
        s1.addr <= addr_sel;
      end
      rsp_valid <= rsp_onehot;
      if (s1.valid) rsp_data <= rf_rd_data;
    end
  end

  // Straight from a flop so the mux-tree select never glitches.
  assign rf_rd_addr = s1.addr;

endmodule
